// File: rtl/transconv_output_collector.sv
// Column accumulator for the transposed-convolution result stream; drains saturated column
// sums serially over valid/ready. Optional ReLU clamp on drained words: COLLECTOR_RELU_EN.
module transconv_output_collector #(
    parameter int unsigned DW       = 16,
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned COL_W    = 4,
    parameter int unsigned ACC_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             partial_valid,
    input  logic [COL_W-1:0] col_id,
    input  logic [DW-1:0]    result_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [COL_W-1:0] out_col,
    output logic             out_last,
    output logic             busy,
    output logic             sat_flag,
    output logic             drop_err
);

    typedef enum logic [0:0] {StAccum, StDrain} state_e;

    localparam logic [COL_W:0]   NumColsW = (COL_W + 1)'(NUM_COLS);
    localparam logic [COL_W-1:0] LastCol  = COL_W'(NUM_COLS - 1);

    localparam logic signed [ACC_W-1:0] AccMax = {{(ACC_W - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AccMin = {{(ACC_W - DW + 1){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic signed [DW-1:0]    OutMax = {1'b0, {(DW - 1){1'b1}}};
    localparam logic signed [DW-1:0]    OutMin = {1'b1, {(DW - 1){1'b0}}};

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [NUM_COLS];
    logic signed [ACC_W-1:0] acc_d [NUM_COLS];
    logic [COL_W-1:0]        drain_col_q, drain_col_d;
    logic                    sat_q, sat_d;
    logic                    drop_q, drop_d;

    logic                    handshake;
    logic                    last_col;
    logic                    col_ok;
    logic                    clipped;
    logic signed [ACC_W-1:0] partial_ext;
    logic signed [ACC_W-1:0] cur_acc;
    logic signed [DW-1:0]    sat_val;
    logic signed [DW-1:0]    drain_val;

    assign handshake   = (state_q == StDrain) && out_ready;
    assign last_col    = (drain_col_q == LastCol);
    assign col_ok      = ({1'b0, col_id} < NumColsW);
    assign partial_ext = {{(ACC_W - DW){result_in[DW-1]}}, result_in};
    assign cur_acc     = acc_q[drain_col_q];

    // Output saturation only; the accumulators themselves wrap at ACC_W.
    always_comb begin
        clipped = 1'b0;
        sat_val = cur_acc[DW-1:0];
        if (cur_acc > AccMax) begin
            sat_val = OutMax;
            clipped = 1'b1;
        end else if (cur_acc < AccMin) begin
            sat_val = OutMin;
            clipped = 1'b1;
        end
    end

`ifdef COLLECTOR_RELU_EN
    assign drain_val = sat_val[DW-1] ? '0 : sat_val;
`else
    assign drain_val = sat_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAccum;
            drain_col_q <= '0;
            sat_q       <= 1'b0;
            drop_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            drain_col_q <= drain_col_d;
            sat_q       <= sat_d;
            drop_q      <= drop_d;
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (flush) state_d = StDrain;
            StDrain: if (handshake && last_col) state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    always_comb begin
        out_valid = (state_q == StDrain);
        busy      = (state_q == StDrain);
        out_col   = drain_col_q;
        out_last  = out_valid && last_col;
        out_data  = out_valid ? drain_val : '0;
        sat_flag  = sat_q;
        drop_err  = drop_q;
    end

    always_comb begin
        drain_col_d = drain_col_q;
        sat_d       = sat_q;
        drop_d      = drop_q;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            acc_d[i] = acc_q[i];
        end
        if (state_q == StAccum) begin
            drain_col_d = '0;
            if (clear) begin
                sat_d  = 1'b0;
                drop_d = 1'b0;
            end
            if (partial_valid && !col_ok) begin
                drop_d = 1'b1;
            end
            // Clear first, then add, so a same-cycle partial survives the clear.
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                if (clear) begin
                    acc_d[i] = '0;
                end
                if (partial_valid && col_ok && (col_id == COL_W'(i))) begin
                    acc_d[i] = acc_d[i] + partial_ext;
                end
            end
        end else begin
            if (partial_valid) begin
                drop_d = 1'b1;
            end
            if (handshake) begin
                if (clipped) begin
                    sat_d = 1'b1;
                end
                if (last_col) begin
                    drain_col_d = '0;
                    for (int i = 0; i < int'(NUM_COLS); i++) begin
                        acc_d[i] = '0;
                    end
                end else begin
                    drain_col_d = drain_col_q + 1'b1;
                end
            end
        end
    end

endmodule
